debug_abstract_cmd_ctrl: RTL

//  Sequences debug abstract commands onto the core monitor's handshakes. Decodes a 32-bit

---
 rtl/debug_abstract_cmd_ctrl_pkg.sv | 48 ++++
 rtl/debug_abstract_cmd_ctrl_timeout_cnt.sv | 35 +++
 rtl/debug_abstract_cmd_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/debug_abstract_cmd_ctrl_pkg.sv
// Shared debug definitions: command field codes, cmderr codes, sequencer states.
package debug_abstract_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_XFER  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_e;

  localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;

  localparam logic [2:0] AARSIZE_32  = 3'd2;
  localparam logic [2:0] AARSIZE_64  = 3'd3;
  localparam logic [2:0] AARSIZE_128 = 3'd4;

  localparam logic [2:0] CMDERR_NONE   = 3'd0;
  localparam logic [2:0] CMDERR_BUSY   = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP = 3'd2;
  localparam logic [2:0] CMDERR_EXC    = 3'd3;
  localparam logic [2:0] CMDERR_HALT   = 3'd4;
  localparam logic [2:0] CMDERR_OTHER  = 3'd7;

  // Fields of an Access Register command kept for the duration of a command
  typedef struct packed {
    logic [7:0]  cmdtype;
    logic [2:0]  aarsize;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } acc_cmd_t;

  // Number of data bits moved by a given aarsize code
  function automatic logic [31:0] aarsize_bits(input logic [2:0] aarsize);
    return 32'd8 << aarsize;
  endfunction

  // Only 32/64/128-bit accesses are supported, and only if they fit the data path
  function automatic logic aarsize_legal(input logic [2:0] aarsize, input int unsigned dw);
    logic size_ok;
    size_ok = (aarsize == AARSIZE_32) || (aarsize == AARSIZE_64) || (aarsize == AARSIZE_128);
    return size_ok && (aarsize_bits(aarsize) <= dw);
  endfunction

endpackage

// File: rtl/debug_abstract_cmd_ctrl_timeout_cnt.sv
// Wait-cycle counter for core handshakes; flags expiry once TIMEOUT cycles have elapsed.
module dbg_timeout_cnt #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Count enabled cycles, saturating at the limit; clear has priority
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/debug_abstract_cmd_ctrl.sv
// Abstract command sequencer: decodes Access Register commands and drives the
// core monitor register-access and program-buffer handshakes.
module debug_abstract_cmd_ctrl
  import debug_abstract_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DW      = 128,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          cmd_wr,
  input  logic [31:0]   cmd,
  input  logic [DW-1:0] arg_in,
  output logic [DW-1:0] res_out,
  output logic          res_wen,
  output logic          busy,
  output logic [2:0]    cmderr,
  input  logic [2:0]    cmderr_clr,
  input  logic          haltreq,
  input  logic          ndmreset,
  output logic          reqHalt,
  output logic          reqReset,
  input  logic          isHalt,
  input  logic          hasReset,
  output logic [DW-1:0] accessReg_arg,
  output logic [15:0]   accessReg_addr,
  output logic          accessReg_wen,
  output logic          accessReg_vaild,
  input  logic          accessReg_ready,
  input  logic [DW-1:0] accessReg_res,
  output logic          quickAccess_vaild,
  input  logic          quickAccess_ready,
  input  logic          isExpection
);

  state_e        state_q, state_d;
  acc_cmd_t      cmd_q, cmd_d;
  logic [DW-1:0] arg_q, arg_d;
  logic [DW-1:0] res_q, res_d;
  logic          res_wen_q, res_wen_d;
  logic          busy_q, busy_d;
  logic [2:0]    cmderr_q, cmderr_d;
  logic          req_halt_q, req_halt_d;
  logic          req_reset_q, req_reset_d;
  logic          has_reset_q, has_reset_d;

  logic          err_set;
  logic [2:0]    err_code;
  logic [2:0]    cmderr_left;
  logic          has_reset_rise;
  logic          to_clr, to_en, to_expired;
  logic [31:0]   xfer_bits;
  logic [DW-1:0] res_mask;
  logic          unused_cmd_bits;

  assign unused_cmd_bits = cmd[23] ^ cmd[19];
  assign has_reset_rise  = hasReset && !has_reset_q;
  assign xfer_bits       = aarsize_bits(cmd_q.aarsize);

  // Keep only the low 8<<aarsize bits of a read result
  always_comb begin
    res_mask = '0;
    for (int i = 0; i < DW; i++) begin
      res_mask[i] = (32'(i) < xfer_bits);
    end
  end

  // Next state, command latch, result capture and sticky error update
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    res_d       = res_q;
    res_wen_d   = 1'b0;
    busy_d      = busy_q;
    req_halt_d  = haltreq;
    req_reset_d = ndmreset;
    has_reset_d = hasReset;
    err_set     = 1'b0;
    err_code    = CMDERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (cmd_wr && (cmderr_q == CMDERR_NONE)) begin
          cmd_d.cmdtype  = cmd[31:24];
          cmd_d.aarsize  = cmd[22:20];
          cmd_d.postexec = cmd[18];
          cmd_d.transfer = cmd[17];
          cmd_d.write    = cmd[16];
          cmd_d.regno    = cmd[15:0];
          arg_d          = arg_in;
          busy_d         = 1'b1;
          state_d        = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (has_reset_rise) begin
          err_set = 1'b1; err_code = CMDERR_OTHER; state_d = ST_ABORT;
        end else if ((cmd_q.cmdtype != CMDTYPE_ACCESS_REG) ||
                     (cmd_q.transfer && !aarsize_legal(cmd_q.aarsize, DW))) begin
          err_set = 1'b1; err_code = CMDERR_NOTSUP; state_d = ST_DONE;
        end else if (!isHalt) begin
          err_set = 1'b1; err_code = CMDERR_HALT; state_d = ST_DONE;
        end else if (cmd_q.transfer) begin
          state_d = ST_XFER;
        end else if (cmd_q.postexec) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_XFER: begin
        if (has_reset_rise) begin
          err_set = 1'b1; err_code = CMDERR_OTHER; state_d = ST_ABORT;
        end else if (accessReg_ready) begin
          if (!cmd_q.write) begin
            res_d     = accessReg_res & res_mask;
            res_wen_d = 1'b1;
          end
          state_d = cmd_q.postexec ? ST_EXEC : ST_DONE;
        end else if (to_expired) begin
          err_set = 1'b1; err_code = CMDERR_OTHER; state_d = ST_ABORT;
        end
      end
      ST_EXEC: begin
        if (has_reset_rise) begin
          err_set = 1'b1; err_code = CMDERR_OTHER; state_d = ST_ABORT;
        end else if (isExpection) begin
          err_set = 1'b1; err_code = CMDERR_EXC; state_d = ST_DONE;
        end else if (quickAccess_ready) begin
          state_d = ST_DONE;
        end else if (to_expired) begin
          err_set = 1'b1; err_code = CMDERR_OTHER; state_d = ST_ABORT;
        end
      end
      ST_DONE, ST_ABORT: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear mask applies first; a new code loads only into an empty register
    cmderr_left = cmderr_q & ~cmderr_clr;
    cmderr_d    = cmderr_left;
    if (cmderr_left == CMDERR_NONE) begin
      if (err_set)               cmderr_d = err_code;
      else if (cmd_wr && busy_q) cmderr_d = CMDERR_BUSY;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      arg_q       <= '0;
      res_q       <= '0;
      res_wen_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmderr_q    <= CMDERR_NONE;
      req_halt_q  <= 1'b0;
      req_reset_q <= 1'b0;
      has_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      res_q       <= res_d;
      res_wen_q   <= res_wen_d;
      busy_q      <= busy_d;
      cmderr_q    <= cmderr_d;
      req_halt_q  <= req_halt_d;
      req_reset_q <= req_reset_d;
      has_reset_q <= has_reset_d;
    end
  end

  // Wait budget restarts on every entry into a handshake state
  assign to_en  = (state_q == ST_XFER) || (state_q == ST_EXEC);
  assign to_clr = (state_d != state_q) && ((state_d == ST_XFER) || (state_d == ST_EXEC));

  dbg_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  assign accessReg_vaild   = (state_q == ST_XFER);
  assign accessReg_addr    = accessReg_vaild ? cmd_q.regno : 16'h0;
  assign accessReg_wen     = accessReg_vaild & cmd_q.write;
  assign accessReg_arg     = accessReg_vaild ? arg_q : '0;
  assign quickAccess_vaild = (state_q == ST_EXEC);

  assign res_out  = res_q;
  assign res_wen  = res_wen_q;
  assign busy     = busy_q;
  assign cmderr   = cmderr_q;
  assign reqHalt  = req_halt_q;
  assign reqReset = req_reset_q;

endmodule
